// File: rtl/hazard_unit_sb.sv
// Pipeline hazard/scoreboard controller: forwarding, stall/flush, one in-flight divide, stall counter.
// Stall/flush/forward/grant are combinational; scoreboard, busy and counter update one edge after cause.
module hazard_unit_sb #(
    parameter int AW     = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        rs1D,
    input  logic [AW-1:0]        rs2D,
    input  logic [AW-1:0]        rdD,
    input  logic                 useRs1D,
    input  logic                 useRs2D,
    input  logic                 divD,
    input  logic [AW-1:0]        rs1E,
    input  logic [AW-1:0]        rs2E,
    input  logic [AW-1:0]        rdE,
    input  logic                 regWriteE,
    input  logic                 loadE,
    input  logic                 divE,
    input  logic                 pc_sel,
    input  logic [AW-1:0]        rdM,
    input  logic [AW-1:0]        rdW,
    input  logic                 regWriteM,
    input  logic                 regWriteW,
    input  logic                 mem_stall,
    input  logic                 div_done,
    input  logic [AW-1:0]        div_rd,
    output logic [1:0]           forwardAE,
    output logic [1:0]           forwardBE,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 stallW,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 div_issue,
    output logic                 div_wb_grant,
    output logic [(1<<AW)-1:0]   sb_pending,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                busy;
    logic [(1<<AW)-1:0]  sbPend;
    logic [CNT_W-1:0]    cnt;
    logic                matchE;
    logic                matchM;
    logic                pendSrc;
    logic                rawNoFwd;
    logic                hz;

    // x0 is hardwired zero, so it never carries a dependency
    assign matchE = (rdE != '0) & ((useRs1D & (rs1D == rdE)) | (useRs2D & (rs2D == rdE)));
    assign matchM = (rdM != '0) & ((useRs1D & (rs1D == rdM)) | (useRs2D & (rs2D == rdM)));
    assign pendSrc = (useRs1D & (rs1D != '0) & sbPend[rs1D])
                   | (useRs2D & (rs2D != '0) & sbPend[rs2D]);
    assign rawNoFwd = (FWD_EN == 0) & ((regWriteE & matchE) | (regWriteM & matchM));

    assign hz = (loadE & matchE) | (divE & matchE) | pendSrc | sbPend[rdD]
              | (divD & (busy | divE)) | rawNoFwd;

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if ((FWD_EN != 0) && !rst) begin
            if (regWriteM && (rdM != '0) && (rs1E == rdM))      forwardAE = 2'b10;
            else if (regWriteW && (rdW != '0) && (rs1E == rdW)) forwardAE = 2'b01;
            if (regWriteM && (rdM != '0) && (rs2E == rdM))      forwardBE = 2'b10;
            else if (regWriteW && (rdW != '0) && (rs2E == rdW)) forwardBE = 2'b01;
        end
    end

    // Redirect outranks the D hazard: the stalled instruction is squashed anyway
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                stallW = 1'b1;
            end else if (pc_sel) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (hz) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    // W-stage writes own the RF port; the divider waits for a free slot
    assign div_issue    = ~rst & divE & ~busy & ~mem_stall;
    assign div_wb_grant = ~rst & div_done & busy & ~regWriteW & ~mem_stall;
    assign sb_pending   = sbPend;
    assign stall_cnt    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            sbPend <= '0;
            cnt    <= '0;
        end else begin
            if (div_issue) begin
                busy <= 1'b1;
                if (rdE != '0) sbPend[rdE] <= 1'b1;
            end
            if (div_wb_grant) begin
                busy         <= 1'b0;
                sbPend[div_rd] <= 1'b0;
            end
            if (stallD && !mem_stall && (cnt != CNT_MAX)) cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Bench for hazard_unit_sb: default instance plus a no-forwarding, 3-bit-counter instance.
module tb_hazard_unit_sb;

    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] HZ   = 13'h0184;
    localparam logic [12:0] MEM  = 13'h01F0;
    localparam logic [12:0] PC   = 13'h000C;
    localparam logic [12:0] ISS  = 13'h0002;
    localparam logic [12:0] GR   = 13'h0001;
    localparam logic [12:0] FA_M = 13'h1000;
    localparam logic [12:0] FA_W = 13'h0800;
    localparam logic [12:0] FB_M = 13'h0400;
    localparam logic [12:0] FB_W = 13'h0200;

    logic clk, rst;
    logic [4:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW, div_rd;
    logic useRs1D, useRs2D, divD, regWriteE, loadE, divE, pc_sel;
    logic regWriteM, regWriteW, mem_stall, div_done;

    logic [1:0]  forwardAE, forwardBE, forwardAE0, forwardBE0;
    logic        stallF, stallD, stallE, stallM, stallW, flushD, flushE, div_issue, div_wb_grant;
    logic        stallF0, stallD0, stallE0, stallM0, stallW0, flushD0, flushE0, div_issue0, div_wb_grant0;
    logic [31:0] sb_pending, sb_pending0;
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt0;

    logic [12:0] ctl, ctl0, expV;
    logic [12:0] expQ[$];
    int nChk = 0;
    int nPass = 0;
    int expCnt = 0;

    assign ctl  = {forwardAE, forwardBE, stallF, stallD, stallE, stallM, stallW,
                   flushD, flushE, div_issue, div_wb_grant};
    assign ctl0 = {forwardAE0, forwardBE0, stallF0, stallD0, stallE0, stallM0, stallW0,
                   flushD0, flushE0, div_issue0, div_wb_grant0};

    hazard_unit_sb dut (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .useRs1D(useRs1D),
        .useRs2D(useRs2D), .divD(divD), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regWriteE(regWriteE), .loadE(loadE), .divE(divE), .pc_sel(pc_sel), .rdM(rdM),
        .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW), .mem_stall(mem_stall),
        .div_done(div_done), .div_rd(div_rd), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .div_issue(div_issue), .div_wb_grant(div_wb_grant),
        .sb_pending(sb_pending), .stall_cnt(stall_cnt)
    );

    hazard_unit_sb #(.AW(5), .FWD_EN(0), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .useRs1D(useRs1D),
        .useRs2D(useRs2D), .divD(divD), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .regWriteE(regWriteE), .loadE(loadE), .divE(divE), .pc_sel(pc_sel), .rdM(rdM),
        .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW), .mem_stall(mem_stall),
        .div_done(div_done), .div_rd(div_rd), .forwardAE(forwardAE0), .forwardBE(forwardBE0),
        .stallF(stallF0), .stallD(stallD0), .stallE(stallE0), .stallM(stallM0), .stallW(stallW0),
        .flushD(flushD0), .flushE(flushE0), .div_issue(div_issue0), .div_wb_grant(div_wb_grant0),
        .sb_pending(sb_pending0), .stall_cnt(stall_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearIn();
        rs1D = '0; rs2D = '0; rdD = '0; rs1E = '0; rs2E = '0; rdE = '0;
        rdM = '0; rdW = '0; div_rd = '0;
        useRs1D = 0; useRs2D = 0; divD = 0; regWriteE = 0; loadE = 0; divE = 0;
        pc_sel = 0; regWriteM = 0; regWriteW = 0; mem_stall = 0; div_done = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearIn();
        rst = 1'b1;
        loadE = 1; rdE = 5'd7; rs1D = 5'd7; useRs1D = 1; divE = 1; divD = 1;
        rs1E = 5'd5; rdM = 5'd5; regWriteM = 1; div_done = 1; div_rd = 5'd7;
        expQ.push_back(NONE);
        expQ.push_back(NONE);
        nextCycle();
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL reset_ctl got %h want %h", ctl, expV); else nPass++;
        expV = expQ.pop_front(); nChk++;
        if (ctl0 !== expV) $display("FAIL reset_ctl_nofwd got %h want %h", ctl0, expV); else nPass++;
        nChk++;
        if (sb_pending !== 32'h0) $display("FAIL reset_sb got %h want 0", sb_pending); else nPass++;
        nChk++;
        if (stall_cnt !== 16'd0 || stall_cnt0 !== 3'd0)
            $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, stall_cnt0);
        else nPass++;
        clearIn();
        rst = 1'b0;
        nextCycle();
    endtask

    task automatic test_forward();
        logic [4:0]  r1 [4] = '{5'd5, 5'd5, 5'd0, 5'd5};
        logic [4:0]  r2 [4] = '{5'd5, 5'd5, 5'd5, 5'd3};
        logic [4:0]  m  [4] = '{5'd5, 5'd5, 5'd5, 5'd3};
        logic        wm [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [12:0] ex [4] = '{FA_M | FB_M, FA_W | FB_W, FB_W, FA_W | FB_M};
        clearIn();
        rdW = 5'd5; regWriteW = 1;
        for (int i = 0; i < 4; i++) begin
            rs1E = r1[i]; rs2E = r2[i]; rdM = m[i]; regWriteM = wm[i];
            expQ.push_back(ex[i]);
            #1;
            expV = expQ.pop_front(); nChk++;
            if (ctl !== expV) $display("FAIL forward_%0d got %h want %h", i, ctl, expV); else nPass++;
            nextCycle();
        end
        clearIn();
    endtask

    task automatic test_load_use();
        clearIn();
        loadE = 1; rdE = 5'd7; rs1D = 5'd7; useRs1D = 1;
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL loaduse_rs1 got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        nChk++;
        if (stall_cnt !== 16'(expCnt)) $display("FAIL loaduse_cnt got %0d want %0d", stall_cnt, expCnt); else nPass++;
        useRs1D = 0;
        expQ.push_back(NONE); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL loaduse_unused got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        useRs2D = 1; rs2D = 5'd7;
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL loaduse_rs2 got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        rdE = 5'd0; rs1D = 5'd0; useRs1D = 1;
        expQ.push_back(NONE); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL loaduse_x0 got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (stall_cnt !== 16'(expCnt)) $display("FAIL loaduse_cnt2 got %0d want %0d", stall_cnt, expCnt); else nPass++;
        clearIn();
    endtask

    task automatic test_divide();
        clearIn();
        divE = 1; rdE = 5'd9; divD = 1; rdD = 5'd10;
        expQ.push_back(HZ | ISS); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_issue_b2b got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        nChk++;
        if (sb_pending !== 32'h200) $display("FAIL div_sb_set got %h want 200", sb_pending); else nPass++;
        clearIn();
        divE = 1; rdE = 5'd3;
        expQ.push_back(NONE); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_busy_noissue got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (sb_pending !== 32'h200) $display("FAIL div_sb_hold got %h want 200", sb_pending); else nPass++;
        clearIn();
        divD = 1; rdD = 5'd10;
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_b2b_busy got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        divD = 0; rdD = 5'd9;
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_waw got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        rdD = 5'd0; rs1D = 5'd9; useRs1D = 1; div_done = 1; div_rd = 5'd9; regWriteW = 1;
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_wb_blocked got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        regWriteW = 0;
        expQ.push_back(HZ | GR); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_wb_grant got %h want %h", ctl, expV); else nPass++;
        nextCycle(); expCnt++;
        nChk++;
        if (sb_pending !== 32'h0) $display("FAIL div_sb_clear got %h want 0", sb_pending); else nPass++;
        div_done = 0;
        expQ.push_back(NONE); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL div_proceed got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (stall_cnt !== 16'(expCnt)) $display("FAIL div_cnt got %0d want %0d", stall_cnt, expCnt); else nPass++;
        clearIn();
        divE = 1; rdE = 5'd0;
        nextCycle();
        nChk++;
        if (sb_pending !== 32'h0) $display("FAIL div_x0_sb got %h want 0", sb_pending); else nPass++;
        clearIn();
        div_done = 1; div_rd = 5'd0;
        nextCycle();
        clearIn();
    endtask

    task automatic test_mem_stall();
        clearIn();
        loadE = 1; rdE = 5'd7; rs1D = 5'd7; useRs1D = 1; pc_sel = 1; mem_stall = 1; divE = 1;
        expQ.push_back(MEM); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL mem_hz_pc got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (sb_pending !== 32'h0 || stall_cnt !== 16'(expCnt))
            $display("FAIL mem_no_update got sb=%h cnt=%0d want sb=0 cnt=%0d", sb_pending, stall_cnt, expCnt);
        else nPass++;
        clearIn();
        divE = 1; rdE = 5'd4;
        nextCycle();
        clearIn();
        div_done = 1; div_rd = 5'd4; mem_stall = 1;
        expQ.push_back(MEM); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL mem_no_grant got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (sb_pending !== 32'h10) $display("FAIL mem_sb_hold got %h want 10", sb_pending); else nPass++;
        mem_stall = 0;
        expQ.push_back(GR); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL mem_release_grant got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        clearIn();
    endtask

    task automatic test_pc_sel();
        clearIn();
        loadE = 1; rdE = 5'd7; rs1D = 5'd7; useRs1D = 1; pc_sel = 1;
        expQ.push_back(PC); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL pcsel_over_hz got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (stall_cnt !== 16'(expCnt)) $display("FAIL pcsel_cnt got %0d want %0d", stall_cnt, expCnt); else nPass++;
        clearIn();
    endtask

    task automatic test_no_forward();
        clearIn();
        rs1E = 5'd5; rdM = 5'd5; regWriteM = 1; rs2E = 5'd6; rdW = 5'd6; regWriteW = 1;
        expQ.push_back(FA_M | FB_W);
        expQ.push_back(NONE); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL fwd_on got %h want %h", ctl, expV); else nPass++;
        expV = expQ.pop_front(); nChk++;
        if (ctl0 !== expV) $display("FAIL fwd_off got %h want %h", ctl0, expV); else nPass++;
        nextCycle();
        clearIn();
        rs1D = 5'd6; useRs1D = 1; regWriteE = 1; rdE = 5'd6;
        expQ.push_back(NONE);
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL raw_e_fwd got %h want %h", ctl, expV); else nPass++;
        expV = expQ.pop_front(); nChk++;
        if (ctl0 !== expV) $display("FAIL raw_e_nofwd got %h want %h", ctl0, expV); else nPass++;
        nextCycle();
        clearIn();
        rs2D = 5'd8; useRs2D = 1; regWriteM = 1; rdM = 5'd8;
        expQ.push_back(HZ); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl0 !== expV) $display("FAIL raw_m_nofwd got %h want %h", ctl0, expV); else nPass++;
        repeat (10) nextCycle();
        nChk++;
        if (stall_cnt0 !== 3'd7) $display("FAIL cnt_saturate got %0d want 7", stall_cnt0); else nPass++;
        clearIn();
    endtask

    task automatic test_reset_mid_divide();
        clearIn();
        divE = 1; rdE = 5'd9;
        nextCycle();
        nChk++;
        if (sb_pending !== 32'h200) $display("FAIL rstdiv_sb_set got %h want 200", sb_pending); else nPass++;
        clearIn();
        div_done = 1; div_rd = 5'd9;
        #2;
        rst = 1'b1;
        #1;
        nChk++;
        if (sb_pending !== 32'h0 || stall_cnt !== 16'd0 || ctl !== NONE)
            $display("FAIL rstdiv_async got sb=%h cnt=%0d ctl=%h want 0/0/0", sb_pending, stall_cnt, ctl);
        else nPass++;
        rst = 1'b0;
        expQ.push_back(NONE); #1;
        expV = expQ.pop_front(); nChk++;
        if (ctl !== expV) $display("FAIL rstdiv_late_done got %h want %h", ctl, expV); else nPass++;
        nextCycle();
        nChk++;
        if (sb_pending !== 32'h0) $display("FAIL rstdiv_sb_after got %h want 0", sb_pending); else nPass++;
        clearIn();
    endtask

    initial begin
        rst = 1'b1;
        clearIn();
        test_reset();
        test_forward();
        test_load_use();
        test_divide();
        test_mem_stall();
        test_pc_sel();
        test_no_forward();
        test_reset_mid_divide();
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule

// File: doc/hazard_unit_sb.md
# hazard_unit_sb

Parametrised hazard/scoreboard controller for the in-order 5-stage RISC-V pipeline. It resolves RAW hazards by forwarding or stalling, load-use and control hazards, and memory-system freezes. It also tracks one outstanding variable-latency divide through a per-register scoreboard. It arbitrates the divider's write-back onto the register-file write port and keeps a saturating stall-cycle counter.

## Interface
- AW, 5: register address width; scoreboard has 2^AW entries.
- FWD_EN, 1: 1 = M/W→E forwarding; 0 = no forwarding, RAW resolved by D-stage stall.
- CNT_W, 16: stall counter width.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1D, rs2D, rdD  in  AW  D-stage source/dest addresses.
- useRs1D, useRs2D  in  1  D instruction actually reads rs1/rs2.
- divD  in  1  D instruction is a divide.
- rs1E, rs2E, rdE  in  AW  E-stage addresses.
- regWriteE, loadE, divE  in  1  E-stage writes rd / is a load / is a divide.
- pc_sel  in  1  taken branch/jump resolved in E.
- rdM, rdW  in  AW; regWriteM, regWriteW  in  1.
- mem_stall  in  1  cache/memory not ready.
- div_done  in  1  divider holds a result; div_rd  in  AW its destination.
- forwardAE, forwardBE  out  2  00 RF, 01 W, 10 M.
- stallF, stallD, stallE, stallM, stallW, flushD, flushE  out  1.
- div_issue  out  1  divider captures E operands this cycle.
- div_wb_grant  out  1  divider result written to RF this cycle.
- sb_pending  out  2^AW  scoreboard bits.
- stall_cnt  out  CNT_W  hazard stall cycles.

## Operation
- Register x0 is never a hazard source: every match term needs the address ≠ 0.
- Forwarding (FWD_EN=1): forwardAE = 10 if rs1E==rdM & regWriteM. Otherwise 01 if rs1E==rdW & regWriteW. Otherwise 00. M has priority. forwardBE is the same using rs2E. With FWD_EN=0, both are always 00.
- matchX(rd) = (useRs1D & rs1D==rd) | (useRs2D & rs2D==rd), rd≠0.
- hz (D hazard) is the OR of the following:
  - loadE & matchX(rdE)
  - divE & matchX(rdE)
  - matchX(r) for any r with sb_pending[r]
  - sb_pending[rdD] (WAW)
  - divD & (busy | divE)
  - if FWD_EN=0: (regWriteE & matchX(rdE)) | (regWriteM & matchX(rdM))
- Priority, highest first:
  - mem_stall: stallF..stallW=1, flushD=flushE=0, div_issue=0, div_wb_grant=0.
  - pc_sel: flushD=flushE=1, stallF=stallD=0. The redirect wins over any hz.
  - hz: stallF=stallD=1, flushE=1.
  - Otherwise: all 0.
- Divider state is a register busy.
  - div_issue = divE & ~busy & ~mem_stall.
  - On issue: busy←1 and sb_pending[rdE]←1 (not set when rdE=0).
- Write-back arbitration: div_wb_grant = div_done & busy & ~regWriteW & ~mem_stall. The W stage has priority on the write port.
  - On grant: busy←0 and sb_pending[div_rd]←0.
  - Issue and grant cannot occur in the same cycle, because issue needs busy=0.
- stall_cnt increments when stallD & ~mem_stall. It saturates at 2^CNT_W−1 and is cleared only by rst.
- rst asynchronously clears busy, sb_pending and stall_cnt. While rst=1, all outputs are 0. A divide in flight at reset is abandoned; a late div_done is ignored because busy=0.

## Timing
- Forward, stall, flush and grant outputs are combinational, with same-cycle response to inputs.
- sb_pending, busy and stall_cnt change one edge after their cause.
- The register file is write-first. A D instruction stalled on sb_pending[r] proceeds in the cycle after the grant edge, reading the new value.
- Divide back-to-back: the second divD is stalled while the first is in E (divE). It stays stalled until the cycle after its grant.

## Test plan
- Forward priority: rs1E=5, rdM=5/regWriteM=1, rdW=5/regWriteW=1 → forwardAE=10. Drop regWriteM → 01. Set rs1E=0 → 00.
- Load-use: loadE=1, rdE=7, rs1D=7, useRs1D=1 → stallF=stallD=flushE=1 and stall_cnt+1. With rdE=0 → no stall.
- Divide dependency: divE, rdE=9, busy=0 → div_issue=1, then sb_pending[9]=1. A dependent D instruction on x9 stalls. div_done with regWriteW=1 → grant=0. With regWriteW=0 → grant=1, and the instruction proceeds next cycle.
- mem_stall during hz and pc_sel → all stalls 1, flushes 0, no issue/grant, stall_cnt unchanged.
- pc_sel together with load-use hazard → flushD=flushE=1, stallF=stallD=0.
- rst asserted mid-divide (busy=1, sb_pending[9]=1) → both cleared immediately. A later div_done gives grant=0.
